// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the fetch/execute sequencer: state encoding,
// instruction width, NOP value and the stack-fault predicate.
package cpu_sequencer_pkg;

    localparam int INSTR_W        = 24;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int JUMP_W         = 8;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } seq_state_t;

    // A push into a full stack or a pop from an empty one aborts the instruction.
    function automatic logic stack_fault(input logic push, input logic pop,
                                         input logic full, input logic empty);
        return (push & full) | (pop & empty);
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute controller: owns pc and ir, paces ROM reads and
// lets the decoder's side effects commit only during the single EXEC cycle.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int ROM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step,
    input  logic                halt_req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [INSTR_W-1:0]  rom_rdata,
    output logic [INSTR_W-1:0]  ir,
    input  logic                dec_jump_enable,
    input  logic [JUMP_W-1:0]   dec_jump_data,
    input  logic                dec_gpr_w_enable,
    input  logic                dec_flags_w_enable,
    input  logic                dec_push_enable,
    input  logic                dec_pop_enable,
    input  logic                stack_full,
    input  logic                stack_empty,
    output logic                gpr_w_commit,
    output logic                flags_w_commit,
    output logic                push_commit,
    output logic                pop_commit,
    output logic [ADDR_W-1:0]   pc,
    output logic [CNT_W-1:0]    retired,
    output logic                halted,
    output logic                fault
);

    localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ROM_LAT - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic              step_mode;
    logic [WAIT_W-1:0] wait_cnt;
    logic              flt;
    logic              in_exec;
    logic              leave_idle;
    logic              exec_stop;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] pc_next;

    // Jump targets arrive 8 bits wide; narrower pcs truncate, wider ones zero-extend.
    if (ADDR_W <= JUMP_W) begin : g_jump_narrow
        assign jump_target = dec_jump_data[ADDR_W-1:0];
    end else begin : g_jump_wide
        assign jump_target = {{(ADDR_W-JUMP_W){1'b0}}, dec_jump_data};
    end

    assign in_exec    = (state == ST_EXEC);
    assign flt        = stack_fault(dec_push_enable, dec_pop_enable, stack_full, stack_empty);
    assign leave_idle = ~halt_req & (run | step);
    assign exec_stop  = halt_req | step_mode | ~run;
    assign pc_next    = dec_jump_enable ? jump_target : pc + ADDR_W'(1);

    assign gpr_w_commit   = in_exec & dec_gpr_w_enable   & ~flt;
    assign flags_w_commit = in_exec & dec_flags_w_enable & ~flt;
    assign push_commit    = in_exec & dec_push_enable    & ~flt;
    assign pop_commit     = in_exec & dec_pop_enable     & ~flt;

    assign rom_addr = pc;
    assign halted   = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (leave_idle) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (flt) begin
                    state_next = ST_FAULT;
                end else if (exec_stop) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    // pc, ir and the retire count only move in EXEC/WAIT, so IDLE holds them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            ir        <= NOP_INSTR;
            retired   <= '0;
            fault     <= 1'b0;
            step_mode <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (leave_idle) begin
                        step_mode <= ~run;
                    end
                end
                ST_FETCH: wait_cnt <= WAIT_LOAD;
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        ir <= rom_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (flt) begin
                        fault <= 1'b1;
                    end else begin
                        pc      <= pc_next;
                        retired <= retired + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/execute controller for the single-cycle combinational instruction decoder.
- Owns the program counter and the 24-bit instruction register (IR); sequences ROM reads.
- Gates the decoder's write/push/pop/jump requests so they commit in exactly one EXEC cycle per instruction.
- Provides run/step/halt control and a sticky stack-fault stop. Sits between ROM, decoder, GPR file, flags and stack.

Parameters:
- ADDR_W, 8, program-counter / ROM address width.
- ROM_LAT, 1, ROM read latency in cycles from rom_addr to valid rom_rdata (>=1).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level: free-run while high
- step  in  1  pulse: execute exactly one instruction from IDLE
- halt_req  in  1  level: stop at next instruction boundary
- rom_addr  out  ADDR_W  ROM read address (= pc)
- rom_rdata  in  24  ROM read data
- ir  out  24  instruction register, feeds decoder rom_data
- dec_jump_enable  in  1  decoder jump request
- dec_jump_data  in  8  decoder jump target
- dec_gpr_w_enable  in  1  decoder GPR write request
- dec_flags_w_enable  in  1  decoder flags write request
- dec_push_enable  in  1  decoder stack push request
- dec_pop_enable  in  1  decoder stack pop request
- stack_full  in  1  stack cannot accept push
- stack_empty  in  1  stack cannot supply pop
- gpr_w_commit  out  1  gated GPR write enable
- flags_w_commit  out  1  gated flags write enable
- push_commit  out  1  gated stack push
- pop_commit  out  1  gated stack pop
- pc  out  ADDR_W  current program counter
- retired  out  CNT_W  instructions retired since reset
- halted  out  1  high in IDLE
- fault  out  1  sticky stack overflow/underflow

Behaviour:
- Reset (sync, any state):
  - state=IDLE, pc=0, ir=0 (NOP), retired=0, fault=0.
  - All commits 0; halted=1. An in-flight instruction is abandoned with no commit.
- States and transitions:
  - IDLE: halted=1.
    - run=1 -> FETCH, step_mode=0.
    - Else step=1 -> FETCH, step_mode=1. run wins if both are high.
    - halt_req=1 blocks leaving IDLE.
  - FETCH (1 cycle): rom_addr=pc. Load wait counter with ROM_LAT-1 -> WAIT.
  - WAIT: counter decrements each cycle. On the cycle the counter is 0, ir<=rom_rdata -> EXEC.
  - EXEC (1 cycle):
    - Commits are combinational: commit_x = (state==EXEC) & dec_x & ~flt.
    - flt = (dec_push_enable & stack_full) | (dec_pop_enable & stack_empty).
  - EXEC, flt=1: no commits, pc unchanged, fault<=1 -> FAULT.
  - EXEC, flt=0:
    - pc <= dec_jump_enable ? dec_jump_data[ADDR_W-1:0] : pc+1 (wraps 255->0).
    - retired <= retired+1 (wraps).
    - Next state: halt_req | step_mode | ~run -> IDLE, else FETCH.
  - FAULT: terminal, halted=0, fault=1. Only rst exits.
- Latency:
  - Cycles per instruction = ROM_LAT+2 (3 at default).
  - First ROM address is presented the cycle after IDLE exit.
- halt_req is never honoured mid-instruction. An asserted halt_req during FETCH/WAIT still completes that instruction.
- step while already running is ignored.
- ir and pc hold their values in IDLE. rom_addr always equals pc.

Decomposition:
- global_params.vh holds:
  - state encodings: IDLE, FETCH, WAIT, EXEC, FAULT (3-bit);
  - NOP opcode / IR reset value;
  - shared widths: ADDR_W and the 24-bit instruction width.
- No sub-module is required. The FSM, pc/ir registers, wait counter and commit gating fit in one module (~200 lines).

Test Plan:
- Reset then run=1, ROM[0..2]=LDR r1,5 / INC r1 / NOP:
  - rom_addr 0,1,2 at 3-cycle spacing;
  - gpr_w_commit pulses once per instruction, on EXEC only;
  - retired reaches 3.
- step pulse in IDLE with pc=4, no jump:
  - exactly one EXEC;
  - pc becomes 5, back to IDLE, halted=1, retired +1.
- EXEC with dec_jump_enable=1, dec_jump_data=0x40 -> next rom_addr=0x40. pc=0xFF without jump -> pc wraps to 0x00.
- Stack faults:
  - dec_push_enable=1 with stack_full=1 -> push_commit=0, gpr/flags commits 0, fault=1, state FAULT, pc unchanged.
  - Pop with stack_empty=1 behaves the same.
- Halt and reset mid-instruction:
  - halt_req raised during WAIT -> that instruction still commits, then IDLE.
  - rst asserted during WAIT -> next cycle state IDLE, pc=0, ir=0, no commit pulse.
